// File: rtl/mips_divider_iter.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU (quotient to LO, remainder to HI).
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module mips_divider_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = WIDTH + BITS_PER_CYCLE;

    if ((WIDTH % 2) != 0 || WIDTH < 4 ||
        !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $error("mips_divider_iter: illegal WIDTH/BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_dd;
    logic [WIDTH-1:0] mag_dv;
    logic [PW-1:0]    pr_step;
    logic [WIDTH-1:0] qq_step;

    // Magnitudes of the incoming operands; -MIN wraps to MIN, which is its unsigned magnitude
    always_comb begin
        mag_dd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        mag_dv = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // BITS_PER_CYCLE restoring shift/compare/subtract steps on the partial remainder
    always_comb begin
        pr_step = prem_q;
        qq_step = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pr_step = {pr_step[PW-2:0], qq_step[WIDTH-1]};
            qq_step = {qq_step[WIDTH-2:0], 1'b0};
            if (pr_step >= {{BITS_PER_CYCLE{1'b0}}, dvs_q}) begin
                pr_step    = pr_step - {{BITS_PER_CYCLE{1'b0}}, dvs_q};
                qq_step[0] = 1'b1;
            end
        end
    end

    // Next-state and result logic for IDLE -> ITER -> FIX -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        raw_d   = raw_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    raw_d   = dividend;
                    dvs_d   = mag_dv;
                    quo_d   = mag_dd;
                    prem_d  = '0;
                    cnt_d   = CW'(N);
                    negq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    negr_d  = is_signed & dividend[WIDTH-1];
                    state_d = S_ITER;
`ifdef DIV_EARLY_OUT_EN
                    if ((divisor != '0) && (mag_dd < mag_dv)) begin
                        quo_d   = '0;
                        prem_d  = {{BITS_PER_CYCLE{1'b0}}, mag_dd};
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_ITER: begin
                prem_d = pr_step;
                quo_d  = qq_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dvs_q == '0) begin
                    qout_d = '1;
                    rout_d = raw_q;
                    dbz_d  = 1'b1;
                end else begin
                    qout_d = negq_q ? -quo_q : quo_q;
                    rout_d = negr_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                    dbz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; everything holds while clk_enable is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            raw_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            raw_q   <= raw_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = qout_q;
    assign remainder   = rout_q;
    assign div_by_zero = dbz_q;

endmodule
